// File: rtl/rpc2_ctrl_reg_access_master.sv
`default_nettype none
// ============================================================================
// Module   : rpc2_ctrl_reg_access_master
// Purpose  : Single-outstanding AXI4 master for the controller's AXIr register
//            port. A simple req/rsp command (write or read) becomes one
//            single-beat AXI transaction. The response code and read data are
//            returned on the rsp channel. A per-transaction watchdog recovers
//            from a slave that never answers.
// Ports    : AXIr_ACLK / AXIr_ARESET   - clock, asynchronous active-high reset
//            req_*                     - command in (valid/ready, write, addr,
//                                        wdata, wstrb)
//            rsp_*                     - response out (valid/ready, rdata,
//                                        resp, timeout)
//            AXIr_AW* / W* / B*        - AXI write address / data / response
//            AXIr_AR* / R*             - AXI read address / data
// Revision : 1.0 - initial release
// ============================================================================
module rpc2_ctrl_reg_access_master #(
   parameter int                  ID_WIDTH       = 4,
   parameter int                  ADDR_WIDTH     = 32,
   parameter int                  DATA_WIDTH     = 32,    // only 32 is supported
   parameter logic [ID_WIDTH-1:0] MASTER_ID      = '0,
   parameter int                  TIMEOUT_CYCLES = 1023   // must be >= 1
) (
   input  logic                    AXIr_ACLK,
   input  logic                    AXIr_ARESET,
   // command / response interface
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   // write address channel
   output logic [ID_WIDTH-1:0]     AXIr_AWID,
   output logic [ADDR_WIDTH-1:0]   AXIr_AWADDR,
   output logic [7:0]              AXIr_AWLEN,
   output logic [2:0]              AXIr_AWSIZE,
   output logic [1:0]              AXIr_AWBURST,
   output logic                    AXIr_AWVALID,
   input  logic                    AXIr_AWREADY,
   // write data channel
   output logic [DATA_WIDTH-1:0]   AXIr_WDATA,
   output logic [DATA_WIDTH/8-1:0] AXIr_WSTRB,
   output logic                    AXIr_WLAST,
   output logic                    AXIr_WVALID,
   input  logic                    AXIr_WREADY,
   // write response channel
   input  logic [ID_WIDTH-1:0]     AXIr_BID,
   input  logic [1:0]              AXIr_BRESP,
   input  logic                    AXIr_BVALID,
   output logic                    AXIr_BREADY,
   // read address channel
   output logic [ID_WIDTH-1:0]     AXIr_ARID,
   output logic [ADDR_WIDTH-1:0]   AXIr_ARADDR,
   output logic [7:0]              AXIr_ARLEN,
   output logic [2:0]              AXIr_ARSIZE,
   output logic [1:0]              AXIr_ARBURST,
   output logic                    AXIr_ARVALID,
   input  logic                    AXIr_ARREADY,
   // read data channel
   input  logic [ID_WIDTH-1:0]     AXIr_RID,
   input  logic [DATA_WIDTH-1:0]   AXIr_RDATA,
   input  logic [1:0]              AXIr_RRESP,
   input  logic                    AXIr_RLAST,
   input  logic                    AXIr_RVALID,
   output logic                    AXIr_RREADY
);

   localparam int                   c_TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TIMER_W-1:0] c_TIMEOUT = c_TIMER_W'(TIMEOUT_CYCLES);
   localparam logic [1:0]           c_SLVERR  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RESP    = 3'd5
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic                    r_awvalid;
   logic                    r_wvalid;
   logic [c_TIMER_W-1:0]    r_timer;
   logic                    r_beat_seen;   // first R beat of this read already captured
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]              r_rsp_resp;
   logic                    r_rsp_timeout;

   logic w_accept;
   logic w_busy;
   logic w_aw_clear;
   logic w_w_clear;
   logic w_b_hs;
   logic w_r_hs;
   logic w_ar_hs;
   logic w_done_ok;
   logic w_expired;
   logic w_abort;
   logic w_bid_bad;
   logic w_rid_bad;
   logic w_unused_addr_lsb;

   // Register accesses are word aligned; the byte offset is dropped.
   assign w_unused_addr_lsb = ^req_addr[1:0];

   assign w_accept   = (r_state == ST_IDLE) && req_valid;
   assign w_busy     = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                       (r_state == ST_RD_REQ) || (r_state == ST_RD_DATA);
   // A write channel is "clear" when it was never pending or handshakes now.
   assign w_aw_clear = !r_awvalid || AXIr_AWREADY;
   assign w_w_clear  = !r_wvalid  || AXIr_WREADY;
   assign w_b_hs     = (r_state == ST_WR_RESP) && AXIr_BVALID;
   assign w_r_hs     = (r_state == ST_RD_DATA) && AXIr_RVALID;
   assign w_ar_hs    = (r_state == ST_RD_REQ)  && AXIr_ARREADY;
   assign w_bid_bad  = (AXIr_BID != MASTER_ID);
   assign w_rid_bad  = (AXIr_RID != MASTER_ID);

   // A completing B/R handshake in the expiry cycle takes priority over the
   // watchdog; a non-final drain beat does not complete, so it still aborts.
   assign w_done_ok  = w_b_hs || (w_r_hs && AXIr_RLAST);
   assign w_expired  = w_busy && (r_timer == c_TIMEOUT);
   assign w_abort    = w_expired && !w_done_ok;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge AXIr_ACLK or posedge AXIr_ARESET) begin
      if (AXIr_ARESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and state-decoded handshake outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      AXIr_ARVALID = 1'b0;
      AXIr_BREADY  = 1'b0;
      AXIr_RREADY  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = req_write ? ST_WR_REQ : ST_RD_REQ;
            end
         end
         ST_WR_REQ: begin
            if (w_abort) begin
               w_state_nxt = ST_RESP;
            end else if (w_aw_clear && w_w_clear) begin
               w_state_nxt = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            AXIr_BREADY = 1'b1;
            if (w_b_hs || w_abort) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RD_REQ: begin
            AXIr_ARVALID = 1'b1;
            if (w_abort) begin
               w_state_nxt = ST_RESP;
            end else if (w_ar_hs) begin
               w_state_nxt = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            AXIr_RREADY = 1'b1;
            if ((w_r_hs && AXIr_RLAST) || w_abort) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Command latch, write-channel valids, watchdog and response capture
   // ------------------------------------------------------------------------
   always_ff @(posedge AXIr_ACLK or posedge AXIr_ARESET) begin
      if (AXIr_ARESET) begin
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_timer       <= '0;
         r_beat_seen   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= 2'b00;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr        <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            r_wdata       <= req_wdata;
            r_wstrb       <= req_wstrb;
            r_awvalid     <= req_write;
            r_wvalid      <= req_write;
            r_timer       <= '0;
            r_beat_seen   <= 1'b0;
            r_rsp_timeout <= 1'b0;
         end

         if (w_busy) begin
            r_timer <= r_timer + 1'b1;
         end

         // AW and W retire independently on their own handshakes.
         if (r_state == ST_WR_REQ) begin
            if (AXIr_AWREADY) begin
               r_awvalid <= 1'b0;
            end
            if (AXIr_WREADY) begin
               r_wvalid <= 1'b0;
            end
         end

         if (w_b_hs) begin
            r_rsp_rdata <= '0;
            r_rsp_resp  <= w_bid_bad ? c_SLVERR : AXIr_BRESP;
         end

         // Only the first beat is reported; a burst answer to a single-beat
         // request is flagged as an error and the remaining beats are drained.
         if (w_r_hs) begin
            if (!r_beat_seen) begin
               r_beat_seen <= 1'b1;
               r_rsp_rdata <= AXIr_RDATA;
               r_rsp_resp  <= (w_rid_bad || !AXIr_RLAST) ? c_SLVERR : AXIr_RRESP;
            end else if (w_rid_bad) begin
               r_rsp_resp  <= c_SLVERR;
            end
         end

         // Hung-slave recovery: VALIDs are withdrawn without a handshake.
         if (w_abort) begin
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_rsp_resp    <= c_SLVERR;
            r_rsp_rdata   <= '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------------
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_resp     = r_rsp_resp;
   assign rsp_timeout  = r_rsp_timeout;

   assign AXIr_AWID    = MASTER_ID;
   assign AXIr_AWADDR  = r_addr;
   assign AXIr_AWLEN   = 8'd0;
   assign AXIr_AWSIZE  = 3'b010;
   assign AXIr_AWBURST = 2'b01;
   assign AXIr_AWVALID = r_awvalid;

   assign AXIr_WDATA   = r_wdata;
   assign AXIr_WSTRB   = r_wstrb;
   assign AXIr_WLAST   = 1'b1;
   assign AXIr_WVALID  = r_wvalid;

   assign AXIr_ARID    = MASTER_ID;
   assign AXIr_ARADDR  = r_addr;
   assign AXIr_ARLEN   = 8'd0;
   assign AXIr_ARSIZE  = 3'b010;
   assign AXIr_ARBURST = 2'b01;

endmodule
`default_nettype wire

// File: tb/tb_rpc2_ctrl_reg_access_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpc2_ctrl_reg_access_master
// Purpose  : Self-checking bench for rpc2_ctrl_reg_access_master. A small
//            configurable AXI slave answers the DUT; a transaction-level model
//            predicts each response and the per-cycle channel contents, and
//            directed steps pin latencies and boundary cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpc2_ctrl_reg_access_master;

   localparam int         c_TO  = 8;
   localparam logic [3:0] c_MID = 4'h0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [3:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [3:0]  wstrb;

   rpc2_ctrl_reg_access_master #(
      .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .MASTER_ID(c_MID), .TIMEOUT_CYCLES(c_TO)
   ) u_dut (
      .AXIr_ACLK(clk), .AXIr_ARESET(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .AXIr_AWID(awid), .AXIr_AWADDR(awaddr), .AXIr_AWLEN(awlen),
      .AXIr_AWSIZE(awsize), .AXIr_AWBURST(awburst), .AXIr_AWVALID(awvalid),
      .AXIr_AWREADY(awready),
      .AXIr_WDATA(wdata), .AXIr_WSTRB(wstrb), .AXIr_WLAST(wlast),
      .AXIr_WVALID(wvalid), .AXIr_WREADY(wready),
      .AXIr_BID(bid), .AXIr_BRESP(bresp), .AXIr_BVALID(bvalid), .AXIr_BREADY(bready),
      .AXIr_ARID(arid), .AXIr_ARADDR(araddr), .AXIr_ARLEN(arlen),
      .AXIr_ARSIZE(arsize), .AXIr_ARBURST(arburst), .AXIr_ARVALID(arvalid),
      .AXIr_ARREADY(arready),
      .AXIr_RID(rid), .AXIr_RDATA(rdata), .AXIr_RRESP(rresp), .AXIr_RLAST(rlast),
      .AXIr_RVALID(rvalid), .AXIr_RREADY(rready)
   );

   // ---------------------------------------------------------------- slave
   int          cfg_aw_delay, cfg_w_delay, cfg_ar_delay, cfg_nbeats;
   bit          cfg_b_never, cfg_r_never;
   logic [1:0]  cfg_bresp, cfg_rresp;
   logic [3:0]  cfg_bid, cfg_rid;
   logic [31:0] cfg_rdata0;

   int s_aw_cnt, s_w_cnt, s_ar_cnt, s_beat, s_rhs;
   bit s_aw_got, s_w_got;

   assign awready = awvalid && (s_aw_cnt >= cfg_aw_delay);
   assign wready  = wvalid  && (s_w_cnt  >= cfg_w_delay);
   assign arready = arvalid && (s_ar_cnt >= cfg_ar_delay);
   assign bid     = cfg_bid;
   assign bresp   = cfg_bresp;
   assign rid     = cfg_rid;
   assign rresp   = cfg_rresp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s_aw_cnt <= 0; s_w_cnt <= 0; s_ar_cnt <= 0; s_beat <= 0; s_rhs <= 0;
         s_aw_got <= 1'b0; s_w_got <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rdata <= '0;
      end else begin
         s_aw_cnt <= (awvalid && !awready) ? s_aw_cnt + 1 : 0;
         s_w_cnt  <= (wvalid  && !wready)  ? s_w_cnt  + 1 : 0;
         s_ar_cnt <= (arvalid && !arready) ? s_ar_cnt + 1 : 0;
         if (bvalid && bready) begin
            bvalid <= 1'b0;
         end else if (!cfg_b_never) begin
            if ((s_aw_got || (awvalid && awready)) && (s_w_got || (wvalid && wready))) begin
               bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0;
            end else begin
               if (awvalid && awready) s_aw_got <= 1'b1;
               if (wvalid && wready)   s_w_got  <= 1'b1;
            end
         end
         if (rvalid && rready) begin
            s_rhs <= s_rhs + 1;
            if (rlast) begin
               rvalid <= 1'b0;
            end else begin
               rdata  <= rdata + 32'h1;
               rlast  <= (s_beat + 2 >= cfg_nbeats);
               s_beat <= s_beat + 1;
            end
         end else if (arvalid && arready && !cfg_r_never) begin
            rvalid <= 1'b1; rdata <= cfg_rdata0; rlast <= (cfg_nbeats <= 1); s_beat <= 0;
         end
      end
   end

   // ------------------------------------------------------------ checking
   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: one expected response per accepted command.
   typedef struct packed { logic [31:0] rdata; logic [1:0] resp; logic to; } rsp_t;
   rsp_t        exp_q[$];
   bit          outstanding = 1'b0;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         outstanding = 1'b0;
      end else begin
         automatic bit   was_idle = !outstanding;
         automatic rsp_t e;
         chk("req_ready", req_ready, was_idle);
         chk("const_fields", {awid, awlen, awsize, awburst, wlast, arid, arlen, arsize, arburst},
             {c_MID, 8'h0, 3'b010, 2'b01, 1'b1, c_MID, 8'h0, 3'b010, 2'b01});
         if (awvalid) chk("awaddr", awaddr, exp_addr);
         if (wvalid)  chk("w_payload", {wdata, wstrb}, {exp_wdata, exp_wstrb});
         if (arvalid) chk("araddr", araddr, exp_addr);
         if (was_idle || rsp_valid)
            chk("axi_quiet", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               chk("rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, exp_q[0]);
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  outstanding = 1'b0;
               end
            end
         end
         if (was_idle && req_valid) begin
            if (req_write) begin
               if (cfg_b_never) e = '{rdata: 32'h0, resp: 2'b10, to: 1'b1};
               else             e = '{rdata: 32'h0, resp: (cfg_bid != c_MID) ? 2'b10 : cfg_bresp, to: 1'b0};
            end else begin
               if (cfg_r_never) e = '{rdata: 32'h0, resp: 2'b10, to: 1'b1};
               else e = '{rdata: cfg_rdata0,
                          resp: (cfg_nbeats > 1 || cfg_rid != c_MID) ? 2'b10 : cfg_rresp, to: 1'b0};
            end
            exp_q.push_back(e);
            outstanding = 1'b1;
            exp_addr  = {req_addr[31:2], 2'b00};
            exp_wdata = req_wdata;
            exp_wstrb = req_wstrb;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic step();
      @(posedge clk); #1;
   endtask

   // Returns one cycle after the accepting edge (cycle T+1).
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
      while (!req_ready && n < 20) begin step(); n++; end
      chk("accept_wait", (n < 20), 1'b1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 40) begin step(); n++; end
      chk("rsp_wait", (n < 40), 1'b1);
   endtask

   initial begin
      int n, awc, wc, extra, c0;
      logic [34:0] snap;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 1;
      cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0; cfg_nbeats = 1;
      cfg_b_never = 0; cfg_r_never = 0; cfg_bresp = 0; cfg_rresp = 0;
      cfg_bid = c_MID; cfg_rid = c_MID; cfg_rdata0 = 0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
      chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
      chk("rst_payload", {awaddr, araddr, wdata, wstrb}, 100'h0);
      rst = 0;
      step();

      // zero-wait write
      issue(1'b1, 32'h0000_0004, 32'hA5A5_0003, 4'hF);
      chk("t1_aw_w_T1", {awvalid, wvalid, req_ready}, 3'b110);
      chk("t1_awaddr", awaddr, 32'h0000_0004);
      step();
      chk("t1_bready_T2", {bready, awvalid, wvalid, rsp_valid}, 4'b1000);
      step();
      chk("t1_rsp_T3", {rsp_valid, rsp_resp, rsp_rdata, rsp_timeout}, {1'b1, 2'b00, 32'h0, 1'b0});
      step();
      chk("t1_idle_T4", {req_ready, rsp_valid}, 2'b10);

      // AWREADY late by 3 cycles, WREADY immediate; unaligned address
      cfg_aw_delay = 3;
      issue(1'b1, 32'h0000_0102, 32'h1111_2222, 4'h3);
      awc = 0; wc = 0; n = 0;
      while (!rsp_valid && n < 20) begin awc += int'(awvalid); wc += int'(wvalid); step(); n++; end
      chk("t2_aw_cycles", awc, 4);
      chk("t2_w_cycles", wc, 1);
      chk("t2_rsp", {rsp_valid, rsp_resp, awaddr}, {1'b1, 2'b00, 32'h0000_0100});
      step();
      extra = 0;
      repeat (3) begin extra += int'(rsp_valid); step(); end
      chk("t2_single_rsp", extra, 0);
      cfg_aw_delay = 0;

      // single-beat read
      cfg_rdata0 = 32'h1234_5678;
      issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      chk("t3_ar_T1", {arvalid, awvalid, req_ready, araddr}, {3'b100, 32'h0000_0010});
      step();
      chk("t3_rready_T2", {rready, rvalid}, 2'b11);
      step();
      chk("t3_rsp_T3", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, 32'h1234_5678, 2'b00});
      step();
      chk("t3_ready_T4", req_ready, 1'b1);

      // two-beat read answer
      cfg_nbeats = 2; cfg_rdata0 = 32'hCAFE_0001; c0 = s_rhs;
      issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      wait_rsp(n);
      chk("t4_latency", n, 3);
      chk("t4_rsp", {rsp_rdata, rsp_resp}, {32'hCAFE_0001, 2'b10});
      chk("t4_beats", s_rhs - c0, 2);
      step();
      cfg_nbeats = 1;

      // BID mismatch, then EXOKAY passthrough, then RID mismatch
      cfg_bid = 4'h5;
      issue(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h1);
      wait_rsp(n);
      chk("t5_bid_bad", {rsp_resp, rsp_rdata}, {2'b10, 32'h0});
      step();
      cfg_bid = c_MID; cfg_bresp = 2'b01;
      issue(1'b1, 32'h0000_000C, 32'h0000_00FF, 4'h8);
      wait_rsp(n);
      chk("t5_exokay", rsp_resp, 2'b01);
      step();
      cfg_bresp = 2'b00; cfg_rid = 4'h3; cfg_rdata0 = 32'h7777_0000;
      issue(1'b0, 32'h0000_0014, 32'h0, 4'h0);
      wait_rsp(n);
      chk("t5_rid_bad", {rsp_resp, rsp_rdata}, {2'b10, 32'h7777_0000});
      step();
      cfg_rid = c_MID;

      // watchdog: B never arrives
      cfg_b_never = 1;
      issue(1'b1, 32'h0000_0030, 32'h0000_0030, 4'hF);
      wait_rsp(n);
      chk("t6_busy_cycles", n, 9);
      chk("t6_quiet", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
      chk("t6_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0});
      step();
      cfg_b_never = 0; cfg_rdata0 = 32'h0BAD_F00D;
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
      wait_rsp(n);
      chk("t6_after", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h0BAD_F00D});
      step();

      // reset while waiting in the read-data phase
      cfg_r_never = 1;
      issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
      step();
      chk("t7_in_rdata", rready, 1'b1);
      rst = 1;
      #1;
      chk("t7_rst_ctl", {req_ready, arvalid, rready, bready, rsp_valid}, 5'b10000);
      chk("t7_rst_vals", {araddr, rsp_rdata, rsp_resp, rsp_timeout}, 67'h0);
      step();
      rst = 0; cfg_r_never = 0;
      step();
      chk("t7_no_rsp", rsp_valid, 1'b0);
      cfg_rdata0 = 32'h0000_6060;
      issue(1'b0, 32'h0000_0060, 32'h0, 4'h0);
      wait_rsp(n);
      chk("t7_recover", {rsp_rdata, rsp_resp}, {32'h0000_6060, 2'b00});
      step();

      // rsp_ready held low for 5 cycles
      rsp_ready = 0; cfg_rdata0 = 32'h5A5A_1234;
      issue(1'b0, 32'h0000_0070, 32'h0, 4'h0);
      wait_rsp(n);
      snap = {rsp_rdata, rsp_resp, rsp_timeout};
      chk("t8_data", snap, {32'h5A5A_1234, 2'b00, 1'b0});
      for (int i = 0; i < 5; i++) begin
         chk("t8_hold", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, snap});
         step();
      end
      rsp_ready = 1;
      step();
      chk("t8_release", {req_ready, rsp_valid}, 2'b10);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
